sprite_mem_arbiter: RTL



---
 rtl/sprite_arb_pkg.sv | 34 +++
 rtl/sprite_tag_pipe.sv | 41 ++++
 rtl/sprite_mem_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/sprite_arb_pkg.sv
// ============================================================================
// Module      : sprite_arb_pkg
// Description : Shared types and default VGA constants for the sprite memory
//               arbiter (owner tags, arbiter states, tag-pipe slot).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sprite_arb_pkg;

  // 1024x768 @ 60 Hz timing on a 65 MHz pixel clock
  localparam int V_VISIBLE = 768;
  localparam int H_TOTAL   = 1344;

  typedef enum logic [1:0] {
    TAG_NONE    = 2'd0,
    TAG_VIDEO   = 2'd1,
    TAG_HOST_RD = 2'd2
  } owner_tag_e;

  typedef enum logic [1:0] {
    ST_SCAN   = 2'd0,
    ST_WINDOW = 2'd1,
    ST_VBLANK = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic       blank;
    owner_tag_e tag;
  } tag_slot_t;

endpackage

`default_nettype wire

// File: rtl/sprite_tag_pipe.sv
// ============================================================================
// Module      : sprite_tag_pipe
// Description : DEPTH-stage delay line that tracks who owns each in-flight
//               BRAM read, cleared to all-zero (TAG_NONE) by async reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_tag_pipe
  import sprite_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [DEPTH-1:0][W-1:0] r_stage;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_stage <= '0;
        else        r_stage <= i_d;
      end
    end else begin : g_deep
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_stage <= '0;
        else        r_stage <= {r_stage[DEPTH-2:0], i_d};
      end
    end
  endgenerate

  assign o_q = r_stage[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/sprite_mem_arbiter.sv
// ============================================================================
// Module      : sprite_mem_arbiter
// Description : Shares the single-port sprite BRAM between VGA scan-out and a
//               host port; returns window-gated pixels MEM_LAT+1 cycles late.
//               Build option SPRITE_ARB_VBLANK_WR_EN confines host writes to
//               vertical blanking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_mem_arbiter
  import sprite_arb_pkg::*;
#(
  parameter  int WIDTH     = 128,
  parameter  int HEIGHT    = 128,
  parameter  int X0        = 0,
  parameter  int Y0        = 0,
  parameter  int DATA_W    = 12,
  parameter  int MEM_LAT   = 2,
  parameter  int V_VISIBLE = sprite_arb_pkg::V_VISIBLE,
  localparam int ADDR_W    = $clog2(WIDTH * HEIGHT)
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic              blank_in,
  input  logic              host_req_in,
  input  logic              host_we_in,
  input  logic [ADDR_W-1:0] host_addr_in,
  input  logic [DATA_W-1:0] host_wdata_in,
  output logic              host_ready_out,
  output logic              host_rvalid_out,
  output logic [DATA_W-1:0] host_rdata_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [DATA_W-1:0] mem_din_out,
  output logic              mem_we_out,
  input  logic [DATA_W-1:0] mem_dout_in,
  output logic [DATA_W-1:0] pixel_out,
  output logic              pixel_valid_out
);

  // Signed beam offsets keep the window test free of unsigned wrap-around
  logic signed [31:0] w_dx;
  logic signed [31:0] w_dy;
  logic signed [31:0] w_v;
  logic               w_hit;
  logic               w_vis_end;
  logic [ADDR_W-1:0]  w_vaddr;

  assign w_dx      = signed'(32'(hcount_in)) - X0;
  assign w_dy      = signed'(32'(vcount_in)) - Y0;
  assign w_v       = signed'(32'(vcount_in));
  assign w_hit     = (w_dx >= 0) && (w_dx < WIDTH) && (w_dy >= 0) && (w_dy < HEIGHT);
  assign w_vis_end = (w_v >= V_VISIBLE);

  arb_state_e r_state;
  arb_state_e w_state_nxt;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= ST_SCAN;
    else           r_state <= w_state_nxt;
  end

  // Next state reflects the current beam, so grant reacts in the same cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_SCAN, ST_WINDOW: begin
        if (w_vis_end)  w_state_nxt = ST_VBLANK;
        else if (w_hit) w_state_nxt = ST_WINDOW;
        else            w_state_nxt = ST_SCAN;
      end
      ST_VBLANK: begin
        if (vcount_in == 10'd0) w_state_nxt = w_hit ? ST_WINDOW : ST_SCAN;
      end
      default: w_state_nxt = ST_SCAN;
    endcase
  end

  logic w_in_win;
  logic w_wr_ok;
  logic w_grant;

  assign w_in_win = (w_state_nxt == ST_WINDOW);

`ifdef SPRITE_ARB_VBLANK_WR_EN
  assign w_wr_ok = (w_state_nxt == ST_VBLANK);
`else
  assign w_wr_ok = 1'b1;
`endif

  assign w_grant = host_req_in & ~w_in_win & (~host_we_in | w_wr_ok);

  assign w_vaddr = w_in_win
                 ? (ADDR_W'(w_dx) + ADDR_W'(w_dy) * ADDR_W'(WIDTH))
                 : '0;

  assign host_ready_out = w_grant;
  assign mem_addr_out   = w_grant ? host_addr_in : w_vaddr;
  assign mem_we_out     = w_grant & host_we_in;
  assign mem_din_out    = (w_grant & host_we_in) ? host_wdata_in : '0;

  tag_slot_t w_slot_in;
  tag_slot_t w_slot_tail;

  always_comb begin
    w_slot_in.blank = blank_in;
    w_slot_in.tag   = TAG_NONE;
    if (w_grant)       w_slot_in.tag = host_we_in ? TAG_NONE : TAG_HOST_RD;
    else if (w_in_win) w_slot_in.tag = TAG_VIDEO;
  end

  sprite_tag_pipe #(
    .DEPTH (MEM_LAT),
    .W     ($bits(tag_slot_t))
  ) u_tag_pipe (
    .clk   (clk_in),
    .rst_n (rst_n_in),
    .i_d   (w_slot_in),
    .o_q   (w_slot_tail)
  );

  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_pixel;
  logic              r_pixel_valid;

  // Tail of the tag pipe lines up with the BRAM data it describes
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_rvalid      <= 1'b0;
      r_rdata       <= '0;
      r_pixel       <= '0;
      r_pixel_valid <= 1'b0;
    end else begin
      r_rvalid <= (w_slot_tail.tag == TAG_HOST_RD);
      if (w_slot_tail.tag == TAG_HOST_RD) r_rdata <= mem_dout_in;
      if ((w_slot_tail.tag == TAG_VIDEO) && !w_slot_tail.blank) begin
        r_pixel       <= mem_dout_in;
        r_pixel_valid <= 1'b1;
      end else begin
        r_pixel       <= '0;
        r_pixel_valid <= 1'b0;
      end
    end
  end

  assign host_rvalid_out = r_rvalid;
  assign host_rdata_out  = r_rdata;
  assign pixel_out       = r_pixel;
  assign pixel_valid_out = r_pixel_valid;

endmodule

`default_nettype wire
